// File: rtl/ddr_types_pkg.sv
// Shared types for the DDR controller read return path: burst tag layout and AXI response codes.
package ddr_types_pkg;

    localparam int DDR_MAX_ID_W = 16;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [DDR_MAX_ID_W-1:0] id;
        logic [7:0]              len;
    } rd_tag_s;

endpackage

// File: rtl/ddr_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry, count gives occupancy.
module ddr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/axi_rd_resp_ctrl.sv
// AXI read-response controller: matches in-order DFI read beats to scheduler tags and drives the R channel.
// Optional macro DDR_RD_ECC_RESP_EN stores the per-beat ECC flag and reports SLVERR on flagged beats.
module axi_rd_resp_ctrl
    import ddr_types_pkg::*;
#(
    parameter  int DATA_W     = 256,
    parameter  int ID_W       = 8,
    parameter  int TAG_DEPTH  = 16,
    parameter  int DATA_DEPTH = 32,
    localparam int FREE_W     = $clog2(DATA_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tag_valid,
    output logic              tag_ready,
    input  logic [ID_W-1:0]   tag_id,
    input  logic [7:0]        tag_len,
    input  logic              dfi_rddata_valid,
    input  logic [DATA_W-1:0] dfi_rddata,
    input  logic              dfi_rddata_ecc_err,
    output logic [FREE_W-1:0] rd_free,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              err_overflow,
    output logic              err_orphan,
    output logic [31:0]       beats_returned
);

`ifdef DDR_RD_ECC_RESP_EN
    localparam int BUF_W = DATA_W + 1;
`else
    localparam int BUF_W = DATA_W;
`endif

    rd_tag_s                          tag_in;
    rd_tag_s                          tag_head;
    logic                             tag_full;
    logic                             tag_empty;
    logic [$clog2(TAG_DEPTH+1)-1:0]   tag_count_unused;
    logic                             tag_push;
    logic                             tag_pop;

    logic [BUF_W-1:0]                 buf_in;
    logic [BUF_W-1:0]                 buf_head;
    logic                             data_full;
    logic                             data_empty;
    logic [FREE_W-1:0]                data_count;
    logic                             data_push;

    logic                             r_pop;
    logic                             beat_hit;
    logic [7:0]                       beat_cnt;
    logic [15:0]                      expected;
    logic [15:0]                      exp_inc;
    logic [15:0]                      exp_dec;
    logic                             unused_bits;

    assign tag_in    = '{id: DDR_MAX_ID_W'(tag_id), len: tag_len};
    assign tag_ready = !tag_full && !rst;
    assign tag_push  = tag_valid && tag_ready;

    // R channel: outputs are forced to zero whenever no beat is presented.
    assign rvalid = !data_empty && !tag_empty;
    assign r_pop  = rvalid && rready;
    assign rlast  = rvalid && (beat_cnt == tag_head.len);
    assign rid    = rvalid ? tag_head.id[ID_W-1:0] : '0;
    assign rdata  = rvalid ? buf_head[DATA_W-1:0] : '0;
    assign tag_pop = r_pop && rlast;

`ifdef DDR_RD_ECC_RESP_EN
    assign buf_in      = {dfi_rddata_ecc_err, dfi_rddata};
    assign rresp       = (rvalid && buf_head[DATA_W]) ? RRESP_SLVERR : RRESP_OKAY;
    assign unused_bits = ^{tag_head.id, tag_count_unused};
`else
    assign buf_in      = dfi_rddata;
    assign rresp       = RRESP_OKAY;
    assign unused_bits = ^{tag_head.id, tag_count_unused, dfi_rddata_ecc_err};
`endif

    // Beats are only owed while expected is non-zero; a full buffer still consumes the expectation.
    assign beat_hit  = dfi_rddata_valid && (expected != 16'd0);
    assign data_push = beat_hit && (!data_full || r_pop);
    assign exp_inc   = tag_push ? (16'(tag_len) + 16'd1) : 16'd0;
    assign exp_dec   = beat_hit ? 16'd1 : 16'd0;

    ddr_sync_fifo #(
        .WIDTH ($bits(rd_tag_s)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .wdata (tag_in),
        .pop   (tag_pop),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count_unused)
    );

    ddr_sync_fifo #(
        .WIDTH (BUF_W),
        .DEPTH (DATA_DEPTH),
        .CW    (FREE_W)
    ) u_data_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (data_push),
        .wdata (buf_in),
        .pop   (r_pop),
        .rdata (buf_head),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt       <= 8'd0;
            expected       <= 16'd0;
            err_overflow   <= 1'b0;
            err_orphan     <= 1'b0;
            beats_returned <= 32'd0;
            rd_free        <= FREE_W'(DATA_DEPTH);
        end else begin
            expected <= expected + exp_inc - exp_dec;
            if (dfi_rddata_valid && (expected == 16'd0)) err_orphan <= 1'b1;
            if (beat_hit && data_full && !r_pop)         err_overflow <= 1'b1;
            if (r_pop) begin
                beats_returned <= beats_returned + 32'd1;
                beat_cnt       <= rlast ? 8'd0 : beat_cnt + 8'd1;
            end
            // Credit reflects the occupancy that results from this cycle's push/pop.
            rd_free <= FREE_W'(DATA_DEPTH) - (data_count + FREE_W'(data_push) - FREE_W'(r_pop));
        end
    end

endmodule

// File: doc/axi_rd_resp_ctrl.md
Name: axi_rd_resp_ctrl

Overview:
Return path of the controller's AXI read channel. Accepts a read tag (ID, burst length) from the scheduler each time a read burst is issued to DRAM. Captures in-order DFI read-data beats into a buffer and drives the AXI R channel (rid, rdata, rresp, rlast) with full rvalid/rready backpressure. Sits between the DFI data path and the AXI slave port; it is the responder for the AXI AR initiator.

Parameters:
DATA_W, 256, AXI/DFI read data width (one DFI beat = one AXI beat)
ID_W, 8, AXI ID width
TAG_DEPTH, 16, outstanding-burst tag FIFO depth (power of 2)
DATA_DEPTH, 32, read-data buffer depth in beats (power of 2)

Ports:
clk  in  1  controller clock
rst  in  1  asynchronous active-high reset
tag_valid  in  1  scheduler pushes a burst tag
tag_ready  out  1  tag FIFO not full
tag_id  in  ID_W  AXI arid of the burst
tag_len  in  8  AXI arlen (beats-1)
dfi_rddata_valid  in  1  one read beat present (no backpressure)
dfi_rddata  in  DATA_W  read beat
dfi_rddata_ecc_err  in  1  uncorrectable ECC on this beat (used only with DDR_RD_ECC_RESP_EN)
rd_free  out  $clog2(DATA_DEPTH+1)  free data-buffer slots (scheduler credit)
rid  out  ID_W  AXI R id
rdata  out  DATA_W  AXI R data
rresp  out  2  AXI R response
rlast  out  1  last beat of burst
rvalid  out  1  R beat valid
rready  in  1  R beat accepted
err_overflow  out  1  sticky: beat arrived with buffer full
err_orphan  out  1  sticky: beat arrived with no expected beats
beats_returned  out  32  count of R handshakes, wraps at 2^32

Behaviour:
- Reset: clk and rst as above; rst asynchronous, active-high. All FIFOs flushed; beat_cnt=0; expected=0. rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, err_*=0, beats_returned=0, tag_ready=0 while rst high, rd_free=DATA_DEPTH. Reset mid-burst discards everything with no partial R completion.
- Tag push: tag_valid&&tag_ready writes {tag_id,tag_len}; expected += tag_len+1 (16-bit counter).
- Beat capture: dfi_rddata_valid with expected==0 -> beat dropped, err_orphan set. Otherwise, if buffer full and no pop this cycle -> beat dropped, err_overflow set, and expected still decremented. Otherwise the beat is written and expected -= 1. Same-cycle tag push and beat: net expected += tag_len.
- Full buffer with simultaneous R pop: push accepted, occupancy unchanged.
- Latency: beat captured at edge N appears with rvalid=1 in the cycle after edge N. The buffer is show-ahead.
- rvalid = data buffer non-empty && tag FIFO non-empty. rid = head tag id; rlast = (beat_cnt == head tag_len); rresp=2'b00 (OKAY).
- AXI hold rule: while rvalid&&!rready, rid/rdata/rresp/rlast stay stable. rvalid never drops without a handshake.
- On handshake: pop data; beats_returned+=1. If rlast: pop tag, beat_cnt=0; else beat_cnt+=1 (8-bit, max 255).
- rd_free = DATA_DEPTH - occupancy, registered, updated the cycle after push/pop. The scheduler issues a burst only if rd_free ≥ outstanding+len+1.
- Sticky errors clear only on rst.

Optional Feature:
DDR_RD_ECC_RESP_EN:
- Defined: the ecc_err bit is stored alongside each beat; rresp=2'b10 (SLVERR) on exactly the beats flagged, OKAY otherwise.
- Undefined: dfi_rddata_ecc_err is ignored and not stored; rresp is constant 2'b00.

Decomposition:
- ddr_types_pkg gains: rd_tag_s {id, len}; RRESP_OKAY=2'b00, RRESP_SLVERR=2'b10.
- One sub-module: ddr_sync_fifo (show-ahead, parameterised width/depth, count output), instanced twice: tag FIFO and data buffer.
- The top holds beat_cnt, expected counter, error flags, perf counter.

Test Plan:
1. Tag {id=0x3A,len=3}, 4 DFI beats D0..D3 back-to-back, rready=1 -> 4 R beats rid=0x3A, rlast only on D3, beats_returned=4.
2. Tags {1,0},{2,1}; rready low 5 cycles then high -> R held stable (rid=1, rlast=1) throughout; then order id1(last), id2, id2(last).
3. 33 beats with tag len=255 and rready=0 -> first 32 buffered, rd_free=0, err_overflow=1 on 33rd; draining yields 32 beats.
4. DFI beat with no tag pushed -> err_orphan=1, rvalid stays 0, rd_free unchanged.
5. Tag len=1, rst asserted after first R beat -> all outputs to reset values asynchronously; post-reset beat raises err_orphan.
6. With DDR_RD_ECC_RESP_EN: len=2, ecc_err on beat 1 only -> rresp 00,10,00; without the macro -> 00,00,00.
